// File: rtl/perips_tcm_banked.sv
// Dual-port TCM with word-interleaved 32-bit banks: port A load/store, port B fetch.
// Define TCM_ERR_EN to flag misaligned/out-of-range accesses; otherwise addresses alias and truncate.
`timescale 1ns/1ps

module perips_tcm_bank #(
  parameter int unsigned ROWS  = 4096,
  parameter int unsigned ROW_W = 12
) (
  input  logic             clk_i,
  input  logic             en,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [ROW_W-1:0] row,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);
  logic [31:0] mem [ROWS];

  always_ff @(posedge clk_i) begin
    if (en) begin
      for (int k = 0; k < 4; k++)
        if (we && be[k]) mem[row][8*k +: 8] <= wdata[8*k +: 8];
      rdata <= mem[row];
    end
  end
endmodule

module perips_tcm_banked #(
  parameter int unsigned RAM_KB     = 32,
  parameter int unsigned NUM_BANKS  = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        a_req_i,
  output logic        a_gnt_o,
  input  logic        a_we_i,
  input  logic [2:0]  a_size_i,
  input  logic [31:0] a_addr_i,
  input  logic [31:0] a_wdata_i,
  output logic        a_rvalid_o,
  output logic [31:0] a_rdata_o,
  output logic        a_err_o,
  input  logic        b_req_i,
  output logic        b_gnt_o,
  input  logic [31:0] b_addr_i,
  output logic        b_rvalid_o,
  output logic [31:0] b_rdata_o,
  output logic        b_err_o
);
  localparam int unsigned RAM_BYTES = RAM_KB * 1024;
  localparam int unsigned LOGB      = $clog2(NUM_BANKS);
  localparam int unsigned BW        = (LOGB > 0) ? LOGB : 1;
  localparam int unsigned ROWS      = RAM_BYTES / (4 * NUM_BANKS);
  localparam int unsigned ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [31:0]      a_off, b_off;
  logic [BW-1:0]    a_bank, b_bank;
  logic [ROW_W-1:0] a_row, b_row;

  assign a_off  = a_addr_i - BASE_ADDR;
  assign b_off  = b_addr_i - BASE_ADDR;
  assign a_bank = (NUM_BANKS > 1) ? a_off[2 +: BW] : '0;
  assign b_bank = (NUM_BANKS > 1) ? b_off[2 +: BW] : '0;
  assign a_row  = a_off[2+LOGB +: ROW_W];
  assign b_row  = b_off[2+LOGB +: ROW_W];

  logic a_err, b_err;
`ifdef TCM_ERR_EN
  assign a_err = (a_size_i[2] ? (a_addr_i[1:0] != 2'b00) : (a_size_i[1] & a_addr_i[0]))
               | (a_off >= 32'(RAM_BYTES));
  assign b_err = (b_addr_i[1:0] != 2'b00) | (b_off >= 32'(RAM_BYTES));
`else
  assign a_err = 1'b0;
  assign b_err = 1'b0;
`endif

  // Upper offset bits only matter for range checking; without it they alias.
  logic unused_ok;
  assign unused_ok = ^{a_off, b_off, a_size_i[0]};

  logic [3:0] a_be;
  always_comb begin
    a_be = 4'b0001 << a_addr_i[1:0];
    if (a_size_i[2])      a_be = 4'hf;
    else if (a_size_i[1]) a_be = a_addr_i[1] ? 4'b1100 : 4'b0011;
  end

  // Erroring requests never touch a bank, so they cannot conflict.
  logic [3:0] starve;
  logic       conflict, b_wins, a_gnt, b_gnt;
  assign conflict = a_req_i & b_req_i & ~a_err & ~b_err & (a_bank == b_bank);
  assign b_wins   = (starve == 4'(STARVE_MAX));
  assign a_gnt    = a_req_i & ~(conflict & b_wins);
  assign b_gnt    = b_req_i & ~(conflict & ~b_wins);
  assign a_gnt_o  = a_gnt;
  assign b_gnt_o  = b_gnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)      starve <= '0;
    else if (b_gnt)    starve <= '0;
    else if (conflict) starve <= starve + 4'd1;
  end

  logic [NUM_BANKS-1:0][31:0] bank_rd;

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    logic a_hit, b_hit;
    assign a_hit = a_gnt & ~a_err & (a_bank == BW'(i));
    assign b_hit = b_gnt & ~b_err & (b_bank == BW'(i));
    perips_tcm_bank #(.ROWS(ROWS), .ROW_W(ROW_W)) u_bank (
      .clk_i (clk_i),
      .en    (a_hit | b_hit),
      .we    (a_hit & a_we_i),
      .be    (a_be),
      .row   (a_hit ? a_row : b_row),
      .wdata (a_wdata_i),
      .rdata (bank_rd[i])
    );
  end

  // Bank outputs change on any later access, so each port keeps its last word.
  logic          a_vld, a_zero, a_err_q, b_vld, b_zero, b_err_q;
  logic [BW-1:0] a_bank_q, b_bank_q;
  logic [31:0]   a_hold, b_hold;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      a_vld <= 1'b0; a_zero <= 1'b0; a_err_q <= 1'b0; a_bank_q <= '0; a_hold <= '0;
      b_vld <= 1'b0; b_zero <= 1'b0; b_err_q <= 1'b0; b_bank_q <= '0; b_hold <= '0;
    end else begin
      a_vld    <= a_gnt;
      a_zero   <= a_we_i | a_err;
      a_err_q  <= a_gnt & a_err;
      a_bank_q <= a_bank;
      b_vld    <= b_gnt;
      b_zero   <= b_err;
      b_err_q  <= b_gnt & b_err;
      b_bank_q <= b_bank;
      if (a_vld) a_hold <= a_rdata_o;
      if (b_vld) b_hold <= b_rdata_o;
    end
  end

  assign a_rvalid_o = a_vld;
  assign a_err_o    = a_err_q;
  assign a_rdata_o  = a_vld ? (a_zero ? '0 : bank_rd[a_bank_q]) : a_hold;
  assign b_rvalid_o = b_vld;
  assign b_err_o    = b_err_q;
  assign b_rdata_o  = b_vld ? (b_zero ? '0 : bank_rd[b_bank_q]) : b_hold;
endmodule

// File: tb/tb_perips_tcm_banked.sv
// Directed bench for perips_tcm_banked: stimulus pushes expected responses, a monitor pops and checks.
`timescale 1ns/1ps

module tb_perips_tcm_banked;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [2:0]  SZ_W = 3'b100, SZ_H = 3'b010, SZ_B = 3'b001;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        a_req = 0, a_gnt, a_we = 0, a_rvalid, a_err;
  logic [2:0]  a_size = 0;
  logic [31:0] a_addr = 0, a_wdata = 0, a_rdata;
  logic        b_req = 0, b_gnt, b_rvalid, b_err;
  logic [31:0] b_addr = 0, b_rdata;

  always #5 clk = ~clk;

  perips_tcm_banked dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .a_req_i(a_req), .a_gnt_o(a_gnt), .a_we_i(a_we), .a_size_i(a_size),
    .a_addr_i(a_addr), .a_wdata_i(a_wdata), .a_rvalid_o(a_rvalid),
    .a_rdata_o(a_rdata), .a_err_o(a_err),
    .b_req_i(b_req), .b_gnt_o(b_gnt), .b_addr_i(b_addr),
    .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata), .b_err_o(b_err)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic [31:0] due;
  } exp_t;

  exp_t        qa[$], qb[$];
  int          checks = 0, errors = 0;
  logic [31:0] cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response must match the oldest outstanding expectation and arrive on time.
  always @(negedge clk) begin
    exp_t e;
    if (a_rvalid) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_rvalid: got unexpected response at cycle %0d expected none", cyc);
      end else begin
        e = qa.pop_front();
        chk("a_rdata", a_rdata, e.data);
        chk("a_err", a_err, e.err);
        chk("a_latency", cyc, e.due);
      end
    end
    if (b_rvalid) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_rvalid: got unexpected response at cycle %0d expected none", cyc);
      end else begin
        e = qb.pop_front();
        chk("b_rdata", b_rdata, e.data);
        chk("b_err", b_err, e.err);
        chk("b_latency", cyc, e.due);
      end
    end
  end

  task automatic step(input logic ar, input logic awe, input logic [2:0] asz,
                      input logic [31:0] aa, input logic [31:0] awd,
                      input logic br, input logic [31:0] ba,
                      input logic eag, input logic ebg,
                      input logic [31:0] ead, input logic eae,
                      input logic [31:0] ebd, input logic ebe);
    @(posedge clk); #1;
    a_req = ar; a_we = awe; a_size = asz; a_addr = aa; a_wdata = awd;
    b_req = br; b_addr = ba;
    @(negedge clk);
    chk("a_gnt", a_gnt, eag);
    chk("b_gnt", b_gnt, ebg);
    if (eag) qa.push_back('{ead, eae, cyc + 1});
    if (ebg) qb.push_back('{ebd, ebe, cyc + 1});
  endtask

  task automatic a_wr(input logic [2:0] sz, input logic [31:0] addr, input logic [31:0] d,
                      input logic e);
    step(1, 1, sz, addr, d, 0, 0, 1, 0, 32'h0, e, 32'h0, 0);
  endtask

  task automatic a_rd(input logic [31:0] addr, input logic [31:0] d, input logic e);
    step(1, 0, SZ_W, addr, 0, 0, 0, 1, 0, d, e, 32'h0, 0);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_a_rvalid", a_rvalid, 0); chk("rst_a_rdata", a_rdata, 0); chk("rst_a_err", a_err, 0);
    chk("rst_b_rvalid", b_rvalid, 0); chk("rst_b_rdata", b_rdata, 0); chk("rst_b_err", b_err, 0);
    #5 rst_n = 1'b1;

    // Reset in the middle of a read: response dropped, committed write retained
    a_wr(SZ_W, BASE + 4, 32'h1234_5678, 0);
    @(posedge clk); #1;
    a_req = 1; a_we = 0; a_size = SZ_W; a_addr = BASE + 4;
    @(negedge clk);
    chk("midrst_gnt", a_gnt, 1);
    @(posedge clk); #1;
    a_req = 0;
    chk("midrst_pre_rvalid", a_rvalid, 1);
    chk("midrst_pre_rdata", a_rdata, 32'h1234_5678);
    rst_n = 1'b0; #1;
    chk("midrst_rvalid", a_rvalid, 0);
    chk("midrst_rdata", a_rdata, 0);
    chk("midrst_err", a_err, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(); idle(); idle();

    // Disjoint banks in the same cycle
    step(1, 1, SZ_W, BASE + 0, 32'hDEAD_BEEF, 1, BASE + 4, 1, 1, 32'h0, 0, 32'h1234_5678, 0);
    a_rd(BASE + 0, 32'hDEAD_BEEF, 0);

    // Byte and half merges into a word
    a_wr(SZ_W, BASE + 8,  32'h1122_3344, 0);
    a_wr(SZ_B, BASE + 9,  32'h0000_AA00, 0);
    a_wr(SZ_H, BASE + 10, 32'hBBCC_0000, 0);
    step(1, 0, SZ_W, BASE + 8, 0, 1, BASE + 4, 1, 1, 32'hBBCC_AA44, 0, 32'h1234_5678, 0);

    // Read-after-write on consecutive cycles, then a fetch of the same word
    a_wr(SZ_W, BASE + 12, 32'h5A5A_5A5A, 0);
    a_rd(BASE + 12, 32'h5A5A_5A5A, 0);
    step(0, 0, 0, 0, 0, 1, BASE + 12, 0, 1, 32'h0, 0, 32'h5A5A_5A5A, 0);

    // Same-bank conflict: A,A,A,B,A,A,A,B
    for (int i = 0; i < 8; i++) begin
      logic bw;
      bw = ((i % 4) == 3);
      step(1, 0, SZ_W, BASE + 0, 0, 1, BASE + 8, !bw, bw,
           32'hDEAD_BEEF, 0, 32'hBBCC_AA44, 0);
    end
    idle();

`ifdef TCM_ERR_EN
    a_rd(BASE + 2, 32'h0, 1);
    a_wr(SZ_W, BASE + 32'h8000, 32'hCAFE_F00D, 1);
    a_rd(BASE + 0, 32'hDEAD_BEEF, 0);
    step(1, 0, SZ_H, BASE + 1, 0, 1, BASE + 6, 1, 1, 32'h0, 1, 32'h0, 1);
    step(1, 0, SZ_W, BASE + 32'h8000, 0, 1, BASE + 0, 1, 1, 32'h0, 1, 32'hDEAD_BEEF, 0);
    a_rd(BASE - 4, 32'h0, 1);
`else
    a_rd(BASE + 2, 32'hDEAD_BEEF, 0);
    a_wr(SZ_W, BASE + 32'h8000, 32'hCAFE_F00D, 0);
    a_rd(BASE + 0, 32'hCAFE_F00D, 0);
    step(1, 0, SZ_H, BASE + 1, 0, 1, BASE + 6, 1, 1, 32'hCAFE_F00D, 0, 32'h1234_5678, 0);
`endif

    idle(); idle(); idle();
    chk("a_outstanding", qa.size(), 0);
    chk("b_outstanding", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
